// File: rtl/ring_pkg.sv
// Shared ring-router definitions: flit layout, field positions, VC buffer state.
package ring_pkg;

  localparam int unsigned DATA_WIDTH  = 64;
  localparam int unsigned VC_BIT      = 63;
  localparam int unsigned DIR_BIT     = 62;
  localparam int unsigned HOP_MSB     = 55;
  localparam int unsigned HOP_LSB     = 48;
  localparam int unsigned HOP_WIDTH   = HOP_MSB - HOP_LSB + 1;
  localparam logic [HOP_WIDTH-1:0] HOP_ARRIVED = 8'h00;

  // Flit view of a DATA_WIDTH word; payload fields are never interpreted here.
  typedef struct packed {
    logic                 vc;
    logic                 dir;
    logic [5:0]           pay_hi;
    logic [HOP_WIDTH-1:0] hop;
    logic [47:0]          pay_lo;
  } flit_t;

  typedef enum logic {
    VC_EMPTY = 1'b0,
    VC_FULL  = 1'b1
  } vc_state_e;

  // A flit whose hop count has run out is delivered to the local PE.
  function automatic logic is_eject(input flit_t f);
    return f.hop == HOP_ARRIVED;
  endfunction

endpackage

// File: rtl/cw_input_vc.sv
// Single virtual-channel receive buffer: one-entry store, EMPTY/FULL FSM,
// route decode (forward vs eject) and overflow detection.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en, wr_data     steered write strobe and flit for this VC
//   gnt_fwd, gnt_ej    release grants from the forward / eject consumers
//   req_fwd, req_ej    registered route requests (at most one high)
//   data_out           buffered flit
//   full_c             buffer occupied (decoded from state register)
//   overflow_c         pulse: write to a full buffer was dropped this cycle
module cw_input_vc
  import ring_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  gnt_fwd,
  input  logic                  gnt_ej,
  output logic                  req_fwd,
  output logic                  req_ej,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full_c,
  output logic                  overflow_c
);

  vc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_fwd_q, req_fwd_d;
  logic                  req_ej_q, req_ej_d;
  logic                  gnt_hit;

  // State, buffer and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= VC_EMPTY;
      data_q    <= '0;
      req_fwd_q <= 1'b0;
      req_ej_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      req_fwd_q <= req_fwd_d;
      req_ej_q  <= req_ej_d;
    end
  end

  // Only a grant that matches the live request releases the buffer; requests
  // are low while EMPTY, so grants to an empty buffer fall out here too.
  assign gnt_hit = (gnt_fwd & req_fwd_q) | (gnt_ej & req_ej_q);

  // Next state and buffer contents.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    overflow_c = 1'b0;
    case (state_q)
      VC_EMPTY: begin
        if (wr_en) begin
          state_d = VC_FULL;
          data_d  = wr_data;
        end
      end
      VC_FULL: begin
        if (wr_en && gnt_hit) begin
          data_d = wr_data;
        end else if (gnt_hit) begin
          state_d = VC_EMPTY;
        end else if (wr_en) begin
          overflow_c = 1'b1;
        end
      end
      default: state_d = VC_EMPTY;
    endcase
  end

  // Requests registered from the next buffer contents, so they line up with data_out.
  always_comb begin
    req_fwd_d = 1'b0;
    req_ej_d  = 1'b0;
    if (state_d == VC_FULL) begin
      req_ej_d  = is_eject(flit_t'(data_d));
      req_fwd_d = ~is_eject(flit_t'(data_d));
    end
  end

  assign full_c   = (state_q == VC_FULL);
  assign req_fwd  = req_fwd_q;
  assign req_ej   = req_ej_q;
  assign data_out = data_q;

endmodule

// File: rtl/cw_input.sv
// Clockwise-ring receive port: steers incoming flits to the even/odd VC
// buffers, drives ready back upstream and keeps a sticky overflow flag.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   polarity                 link phase (0 even VC, 1 odd VC)
//   cwsi, cwdi, cwri         upstream strobe, flit, ready
//   req_{fwd,ej}_{even,odd}  route requests per VC
//   gnt_{fwd,ej}_{even,odd}  release grants per VC
//   data_out_{even,odd}      buffered flits
//   err_overflow             sticky dropped-write flag
module cw_input
  import ring_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  cwsi,
  input  logic [DATA_WIDTH-1:0] cwdi,
  output logic                  cwri,
  output logic                  req_fwd_even,
  output logic                  req_fwd_odd,
  output logic                  req_ej_even,
  output logic                  req_ej_odd,
  input  logic                  gnt_fwd_even,
  input  logic                  gnt_fwd_odd,
  input  logic                  gnt_ej_even,
  input  logic                  gnt_ej_odd,
  output logic [DATA_WIDTH-1:0] data_out_even,
  output logic [DATA_WIDTH-1:0] data_out_odd,
  output logic                  err_overflow
);

  logic wr_even, wr_odd;
  logic full_even, full_odd;
  logic ovf_even, ovf_odd;
  logic err_overflow_q, err_overflow_d;

  // VC bit of the flit selects the destination buffer.
  assign wr_even = cwsi & ~cwdi[VC_BIT];
  assign wr_odd  = cwsi &  cwdi[VC_BIT];

  cw_input_vc u_vc_even (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_even),
    .wr_data    (cwdi),
    .gnt_fwd    (gnt_fwd_even),
    .gnt_ej     (gnt_ej_even),
    .req_fwd    (req_fwd_even),
    .req_ej     (req_ej_even),
    .data_out   (data_out_even),
    .full_c     (full_even),
    .overflow_c (ovf_even)
  );

  cw_input_vc u_vc_odd (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_odd),
    .wr_data    (cwdi),
    .gnt_fwd    (gnt_fwd_odd),
    .gnt_ej     (gnt_ej_odd),
    .req_fwd    (req_fwd_odd),
    .req_ej     (req_ej_odd),
    .data_out   (data_out_odd),
    .full_c     (full_odd),
    .overflow_c (ovf_odd)
  );

  // Ready reflects the VC owning the current link phase; state-only, no cwsi path.
  assign cwri = polarity ? ~full_odd : ~full_even;

  // Sticky overflow, cleared only by reset.
  assign err_overflow_d = err_overflow_q | ovf_even | ovf_odd;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_q <= 1'b0;
    end else begin
      err_overflow_q <= err_overflow_d;
    end
  end

  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_cw_input.sv
module tb_cw_input;

  logic        clk = 1'b0;
  logic        rst;
  logic        polarity;
  logic        cwsi;
  logic [63:0] cwdi;
  logic        cwri;
  logic        req_fwd_even, req_fwd_odd, req_ej_even, req_ej_odd;
  logic        gnt_fwd_even, gnt_fwd_odd, gnt_ej_even, gnt_ej_odd;
  logic [63:0] data_out_even, data_out_odd;
  logic        err_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [63:0] F_FWD_E = 64'h0004_0000_0000_00AA; // even, hop 0x04
  localparam logic [63:0] F_EJ_O  = 64'h8000_0000_0000_0055; // odd, hop 0
  localparam logic [63:0] F_E_H2  = 64'h0002_0000_0000_1111; // even, hop 0x02
  localparam logic [63:0] F_O_H3  = 64'h8003_0000_0000_2222; // odd, hop 0x03
  localparam logic [63:0] F_E_H0  = 64'h0000_0400_0000_3333; // even, hop 0 (bit 42 is payload)
  localparam logic [63:0] F_E_H5  = 64'h0005_0000_0000_4444; // even, hop 0x05

  always #5 clk = ~clk;

  cw_input dut (
    .clk           (clk),
    .rst           (rst),
    .polarity      (polarity),
    .cwsi          (cwsi),
    .cwdi          (cwdi),
    .cwri          (cwri),
    .req_fwd_even  (req_fwd_even),
    .req_fwd_odd   (req_fwd_odd),
    .req_ej_even   (req_ej_even),
    .req_ej_odd    (req_ej_odd),
    .gnt_fwd_even  (gnt_fwd_even),
    .gnt_fwd_odd   (gnt_fwd_odd),
    .gnt_ej_even   (gnt_ej_even),
    .gnt_ej_odd    (gnt_ej_odd),
    .data_out_even (data_out_even),
    .data_out_odd  (data_out_odd),
    .err_overflow  (err_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cwsi = 1'b0; cwdi = '0;
    gnt_fwd_even = 1'b0; gnt_fwd_odd = 1'b0;
    gnt_ej_even  = 1'b0; gnt_ej_odd  = 1'b0;
  endtask

  task automatic send(input logic [63:0] f);
    cwsi = 1'b1; cwdi = f;
    step();
    cwsi = 1'b0; cwdi = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_fwd_even"}, 64'(req_fwd_even), 64'd0);
    chk({tag, "_req_fwd_odd"},  64'(req_fwd_odd),  64'd0);
    chk({tag, "_req_ej_even"},  64'(req_ej_even),  64'd0);
    chk({tag, "_req_ej_odd"},   64'(req_ej_odd),   64'd0);
    chk({tag, "_data_even"},    data_out_even,     64'd0);
    chk({tag, "_data_odd"},     data_out_odd,      64'd0);
    chk({tag, "_err"},          64'(err_overflow), 64'd0);
    polarity = 1'b0; #1;
    chk({tag, "_cwri_p0"}, 64'(cwri), 64'd1);
    polarity = 1'b1; #1;
    chk({tag, "_cwri_p1"}, 64'(cwri), 64'd1);
    polarity = 1'b0; #1;
  endtask

  initial begin
    rst = 1'b1; polarity = 1'b0;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    check_reset_state("rst0");

    // Forward on even VC.
    send(F_FWD_E);
    chk("fwd_req_fwd_even", 64'(req_fwd_even), 64'd1);
    chk("fwd_req_ej_even",  64'(req_ej_even),  64'd0);
    chk("fwd_data_even",    data_out_even,     F_FWD_E);
    chk("fwd_cwri_p0",      64'(cwri),         64'd0);
    polarity = 1'b1; #1;
    chk("fwd_cwri_p1",      64'(cwri),         64'd1);
    polarity = 1'b0;
    gnt_fwd_even = 1'b1; step(); gnt_fwd_even = 1'b0;
    chk("fwd_rel_req",      64'(req_fwd_even), 64'd0);
    chk("fwd_rel_cwri",     64'(cwri),         64'd1);

    // Eject on odd VC; the mismatching forward grant is ignored.
    send(F_EJ_O);
    chk("ej_req_ej_odd",    64'(req_ej_odd),   64'd1);
    chk("ej_req_fwd_odd",   64'(req_fwd_odd),  64'd0);
    chk("ej_even_quiet",    64'({req_fwd_even, req_ej_even}), 64'd0);
    chk("ej_data_odd",      data_out_odd,      F_EJ_O);
    polarity = 1'b1; #1;
    chk("ej_cwri_p1",       64'(cwri),         64'd0);
    gnt_fwd_odd = 1'b1; step(); gnt_fwd_odd = 1'b0;
    chk("ej_wrong_gnt",     64'(req_ej_odd),   64'd1);
    gnt_ej_odd = 1'b1; step(); gnt_ej_odd = 1'b0;
    chk("ej_rel_req",       64'(req_ej_odd),   64'd0);
    chk("ej_rel_cwri_p1",   64'(cwri),         64'd1);
    polarity = 1'b0;

    // Grant to an empty buffer has no effect.
    gnt_ej_even = 1'b1; gnt_fwd_even = 1'b1; step(); idle_inputs();
    chk("empty_gnt_reqs",   64'({req_fwd_even, req_ej_even}), 64'd0);
    chk("empty_gnt_cwri",   64'(cwri),         64'd1);

    // VC independence.
    send(F_E_H2);
    send(F_O_H3);
    chk("ind_both_fwd",     64'({req_fwd_even, req_fwd_odd}), 64'b11);
    gnt_fwd_odd = 1'b1; step(); gnt_fwd_odd = 1'b0;
    chk("ind_odd_rel",      64'(req_fwd_odd),  64'd0);
    chk("ind_even_kept",    64'(req_fwd_even), 64'd1);
    chk("ind_even_data",    data_out_even,     F_E_H2);

    // Same-cycle grant and write on even: hop 0x02 replaced by hop 0.
    cwsi = 1'b1; cwdi = F_E_H0; gnt_fwd_even = 1'b1;
    step(); idle_inputs();
    chk("sc_req_fwd_even",  64'(req_fwd_even), 64'd0);
    chk("sc_req_ej_even",   64'(req_ej_even),  64'd1);
    chk("sc_data_even",     data_out_even,     F_E_H0);
    chk("sc_no_err",        64'(err_overflow), 64'd0);
    chk("sc_cwri_p0",       64'(cwri),         64'd0);

    // Overflow: even full, second flit without grant is dropped.
    send(F_E_H5);
    chk("ovf_data_even",    data_out_even,     F_E_H0);
    chk("ovf_req_ej_even",  64'(req_ej_even),  64'd1);
    chk("ovf_req_fwd_even", 64'(req_fwd_even), 64'd0);
    chk("ovf_err",          64'(err_overflow), 64'd1);
    gnt_ej_even = 1'b1; step(); gnt_ej_even = 1'b0;
    step();
    chk("ovf_err_sticky",   64'(err_overflow), 64'd1);
    chk("ovf_rel_req",      64'(req_ej_even),  64'd0);

    // Reset mid-traffic with both buffers occupied.
    send(F_FWD_E);
    send(F_EJ_O);
    chk("pre_rst_full",     64'({req_fwd_even, req_ej_odd}), 64'b11);
    rst = 1'b1; step(); step(); rst = 1'b0;
    check_reset_state("rst1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
